// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - iterative ARM rotated-immediate encoder
// Tests one even rotation per cycle and reports the smallest-rot encoding or not-encodable.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        ready,
  output logic        done,
  output logic        valid,
  output logic [11:0] imm12
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t      state;
  logic [31:0] val_q;
  logic [3:0]  r;
  logic [5:0]  sh;
  logic [5:0]  rsh;
  logic [31:0] cand;

  // Left-rotate by 2r; a shift by 32 yields zero, so r=0 needs no special case.
  assign sh   = {1'b0, r, 1'b0};
  assign rsh  = 6'd32 - sh;
  assign cand = (val_q << sh) | (val_q >> rsh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      valid <= 1'b0;
      imm12 <= 12'h000;
      r     <= 4'd0;
      val_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            val_q <= value;
            r     <= 4'd0;
            ready <= 1'b0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (cand[31:8] == 24'h0) begin
            imm12 <= {r, cand[7:0]};
            valid <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (r == 4'd15) begin
            imm12 <= 12'h000;
            valid <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r <= r + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - randomized self-checking bench for imm_encoder
// Reference searches the decode direction: smallest rot, then imm8, whose ROR equals the value.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'h0;
  logic        ready;
  logic        done;
  logic        valid;
  logic [11:0] imm12;

  int total = 0;
  int bad   = 0;

  imm_encoder dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .ready(ready), .done(done), .valid(valid), .imm12(imm12)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [31:0] v, output logic [11:0] imm,
                                output bit ok, output int lat);
    logic [63:0] t;
    logic [31:0] dec;
    imm = 12'h000;
    ok  = 1'b0;
    lat = 17;
    for (int rot = 15; rot >= 0; rot--) begin
      for (int i = 255; i >= 0; i--) begin
        t   = {32'(i), 32'h0} >> (2 * rot);
        dec = t[63:32] | t[31:0];
        if (dec == v) begin
          imm = {rot[3:0], i[7:0]};
          ok  = 1'b1;
          lat = rot + 2;
        end
      end
    end
  endfunction

  task automatic issue(input logic [31:0] v, input bit hold);
    int w = 0;
    while (!ready && w < 40) begin
      step();
      w++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready: ready=%b required=1 value=%h", ready, v);
    end
    start = 1'b1;
    value = v;
    step();
    if (!hold) start = 1'b0;
    value = $urandom;
  endtask

  task automatic wait_done(input int c0, output int cnt, output bit saw_ready);
    cnt = c0;
    saw_ready = 1'b0;
    while (!done && cnt < 40) begin
      if (ready) saw_ready = 1'b1;
      step();
      cnt++;
    end
    if (ready) saw_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    total += 4;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b want=1", ready); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b want=0", done); end
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b want=0", valid); end
    if (imm12 !== 12'h000) begin bad++; $display("FAIL reset_imm12: got=%h want=000", imm12); end
    rst = 1'b0;
    step();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got=%b want=1", ready); end
  endtask

  task automatic test_directed();
    logic [31:0] dv [6] = '{32'h000000FF, 32'hFF000000, 32'hF000000F,
                            32'h000003FC, 32'h00000000, 32'h00000102};
    logic [11:0] di [6] = '{12'h0FF, 12'h4FF, 12'h2FF, 12'hFFF, 12'h000, 12'h000};
    bit          dk [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int          dl [6] = '{2, 6, 4, 17, 2, 17};
    int cnt;
    bit sr;
    for (int k = 0; k < 6; k++) begin
      issue(dv[k], 1'b0);
      wait_done(1, cnt, sr);
      total += 4;
      if (cnt != dl[k]) begin bad++; $display("FAIL dir_latency[%0d]: got=%0d want=%0d", k, cnt, dl[k]); end
      if (valid !== dk[k]) begin bad++; $display("FAIL dir_valid[%0d]: got=%b want=%b", k, valid, dk[k]); end
      if (imm12 !== di[k]) begin bad++; $display("FAIL dir_imm12[%0d]: got=%h want=%h", k, imm12, di[k]); end
      if (sr !== 1'b0) begin bad++; $display("FAIL dir_ready_busy[%0d]: got=%b want=0", k, sr); end
      step();
      total += 2;
      if (done !== 1'b0) begin bad++; $display("FAIL dir_done_pulse[%0d]: got=%b want=0", k, done); end
      if (ready !== 1'b1) begin bad++; $display("FAIL dir_ready_back[%0d]: got=%b want=1", k, ready); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] b;
    logic [11:0] ei;
    bit ek, sr;
    int el, cnt, s, sel;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      if (sel <= 1) begin
        b = {24'h0, 8'($urandom)};
        s = 2 * $urandom_range(0, 15);
        v = (b >> s) | (b << (32 - s));
      end else if (sel == 2) begin
        v = $urandom;
      end else begin
        v = 32'($urandom_range(0, 1023)) << $urandom_range(0, 22);
      end
      model(v, ei, ek, el);
      issue(v, 1'b0);
      wait_done(1, cnt, sr);
      total += 3;
      if (cnt != el) begin bad++; $display("FAIL rnd_latency: value=%h got=%0d want=%0d", v, cnt, el); end
      if (valid !== ek) begin bad++; $display("FAIL rnd_valid: value=%h got=%b want=%b", v, valid, ek); end
      if (imm12 !== ei) begin bad++; $display("FAIL rnd_imm12: value=%h got=%h want=%h", v, imm12, ei); end
    end
  endtask

  task automatic test_ignore_start();
    int cnt;
    bit sr;
    issue(32'h000003FC, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      start = 1'b1;
      value = 32'h000000FF << k;
      step();
    end
    start = 1'b0;
    wait_done(6, cnt, sr);
    total += 3;
    if (cnt != 17) begin bad++; $display("FAIL ign_latency: got=%0d want=17", cnt); end
    if (valid !== 1'b1) begin bad++; $display("FAIL ign_valid: got=%b want=1", valid); end
    if (imm12 !== 12'hFFF) begin bad++; $display("FAIL ign_imm12: got=%h want=FFF", imm12); end
    step();
    step();
    total += 2;
    if (ready !== 1'b1) begin bad++; $display("FAIL ign_no_queue_ready: got=%b want=1", ready); end
    if (done !== 1'b0) begin bad++; $display("FAIL ign_no_queue_done: got=%b want=0", done); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bit sr;
    issue(32'h000000FF, 1'b1);
    value = 32'hFF000000;
    wait_done(1, cnt, sr);
    total += 2;
    if (cnt != 2) begin bad++; $display("FAIL b2b_first_latency: got=%0d want=2", cnt); end
    if (imm12 !== 12'h0FF) begin bad++; $display("FAIL b2b_first_imm12: got=%h want=0FF", imm12); end
    step();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_done: got=%b want=1", ready); end
    step();
    start = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accepted: ready=%b want=0", ready); end
    wait_done(1, cnt, sr);
    total += 3;
    if (cnt != 6) begin bad++; $display("FAIL b2b_second_latency: got=%0d want=6", cnt); end
    if (valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid: got=%b want=1", valid); end
    if (imm12 !== 12'h4FF) begin bad++; $display("FAIL b2b_second_imm12: got=%h want=4FF", imm12); end
  endtask

  task automatic test_reset_mid_search();
    int cnt;
    bit sr;
    bit saw_done = 1'b0;
    issue(32'h000003FC, 1'b0);
    step();
    step();
    rst = 1'b1;
    #1;
    total += 4;
    if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got=%b want=1", ready); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got=%b want=0", done); end
    if (valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got=%b want=0", valid); end
    if (imm12 !== 12'h000) begin bad++; $display("FAIL rst_mid_imm12: got=%h want=000", imm12); end
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    total += 2;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL rst_mid_no_done: got=%b want=0", saw_done); end
    if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after: got=%b want=1", ready); end
    issue(32'hFF000000, 1'b0);
    wait_done(1, cnt, sr);
    total += 3;
    if (cnt != 6) begin bad++; $display("FAIL rst_after_latency: got=%0d want=6", cnt); end
    if (valid !== 1'b1) begin bad++; $display("FAIL rst_after_valid: got=%b want=1", valid); end
    if (imm12 !== 12'h4FF) begin bad++; $display("FAIL rst_after_imm12: got=%h want=4FF", imm12); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_search();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Iterative encoder that converts a 32-bit constant into the 12-bit ARM data-processing immediate field {rot[3:0], imm8[7:0]}, where value = ROR(zero-extended imm8, 2*rot). It is the inverse of the decode-side immediate extenders and sits in the assembler/constant-load path ahead of the instruction-word builder. It tests one rotation per clock and reports either the canonical (smallest-rot) encoding or "not encodable" through a start/done handshake.

## Interface
- No parameters. Widths are fixed: 32-bit input, 12-bit field.
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only in a cycle where ready=1
- value  in  32  constant to encode; sampled on the accepting edge only
- ready  out  1  1 in IDLE only
- done  out  1  one-cycle pulse when a result is published
- valid  out  1  1 = encodable; meaningful from done onward, held until next done
- imm12  out  12  {rot, imm8}; 12'h000 when valid=0; held until next done

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE: ready=1. start=1 -> latch value into val_q, r<=0, go to SEARCH.
- SEARCH: one test per cycle. cand = ROL(val_q, 2*r), a 32-bit rotate, no bits lost.
  - cand[31:8]==0 -> imm12<={r[3:0], cand[7:0]}, valid<=1, go to DONE.
  - No match and r==15 -> imm12<=0, valid<=0, go to DONE.
  - Otherwise r<=r+1. r is 4 bits and never wraps past 15 within a search.
- DONE: done=1 for exactly this cycle, then return to IDLE.
- The first match in ascending r is required, giving the canonical encoding. value=0 yields imm12=0, valid=1.
- start while ready=0 is ignored, with no queuing. value changes after acceptance have no effect.
- start in the same cycle as done: not accepted, because ready=0. It can be accepted in the following IDLE cycle.
- valid/imm12 change only on the edge that enters DONE.

## Timing
- Reset (async) values: state=IDLE, ready=1, done=0, valid=0, imm12=12'h000, r=0, val_q=0.
- Reset asserted mid-SEARCH or in DONE: return to IDLE immediately. No done pulse is issued, and previous results are cleared.
- Start accepted on the edge ending cycle T. SEARCH tests r=k in cycle T+1+k. Match at r=k -> done high in cycle T+2+k.
- Best-case latency: done in cycle T+2 (r=0). Worst case (r=15 or unencodable): done in T+17.
- Throughput: one request per 3 to 18 cycles. ready returns to 1 in the cycle after done.
- All outputs are registered. No combinational path from start/value to any output.

## Test plan
- Reset then value=32'h000000FF, start in cycle T -> done in T+2, valid=1, imm12=12'h0FF, ready=0 during T+1..T+2.
- value=32'hFF000000 -> r=4, imm12=12'h4FF, valid=1, done in T+6. value=32'hF000000F -> imm12=12'h2FF, done in T+4.
- value=32'h000003FC -> imm12=12'hFFF (r=15 only), done in T+17. value=32'h00000000 -> imm12=12'h000, valid=1, done in T+2.
- value=32'h00000102 (unencodable) -> done in T+17, valid=0, imm12=12'h000. Previous valid result is overwritten at that done.
- During a search: start pulses with a different value in cycles T+1..T+5 -> ignored, result unchanged. start held high through done -> second request accepted one cycle after done.
- rst pulsed in cycle T+3 of a 16-cycle search -> all outputs at reset values immediately, no done pulse, ready=1 after release. A subsequent request completes normally.
